expr_eval: RTL and testbench
============================

# expr_eval

Streaming evaluator for single-digit arithmetic expressions over ASCII, e.g. `1+2*3=`. It sits directly downstream of the character-stream syntax checker and consumes the same byte stream, one character per valid cycle. It evaluates with `*` binding tighter than `+` and reports a registered result, an error flag, and an optional overflow flag when it accepts the terminating `=`.

## Interface
Parameters:
- W, 16, result/accumulator width in bits; all arithmetic is modulo 2^W. W ≥ 4.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in  input  8  ASCII character.
- in_valid  input  1  `in` is consumed on a rising clk edge when this is high; otherwise state holds.
- result  output  W  value of the last completed expression; holds until the next `=`.
- result_valid  output  1  one-cycle pulse when a `=` is accepted.
- err  output  1  syntax error for the last completed expression; valid with result_valid and holds after.
- ovf  output  1  arithmetic overflow for the last completed expression; see Configuration.

## Operation
- Character classes: digit `0`–`9` (0x30–0x39, value = in−0x30); PLUS 0x2B; MUL 0x2A; EQ 0x3D; any other byte is ILLEGAL.
- Registers: sum[W], term[W], mul_pend (last operator was MUL), err_acc (sticky), ovf_acc (sticky).
- FSM states:
  - S_START: expecting the first digit. Digit → term=d, mul_pend=0, go to S_OPND. PLUS/MUL/ILLEGAL → err_acc=1, go to S_ERR. EQ → complete with err=1 (empty expression), stay in S_START.
  - S_OPND: a digit was just accepted. PLUS → sum=sum+term, mul_pend=0, go to S_OPER. MUL → mul_pend=1, go to S_OPER. EQ → complete. Digit/ILLEGAL → err_acc=1, go to S_ERR.
  - S_OPER: an operator was just accepted. Digit → term = mul_pend ? term*d : d, go to S_OPND. PLUS/MUL/ILLEGAL → S_ERR. EQ → complete with err=1.
  - S_ERR: absorbs all characters except EQ. EQ → complete with err=1.
- Completion (on EQ): result ← sum+term (or 0 if err), err ← error status, ovf ← ovf_acc, pulse result_valid; then clear sum, term, mul_pend, err_acc, ovf_acc and go to S_START.
- Widths: term*d is computed at W+4 bits and sum+term at W+1 bits, then truncated to W. Truncated bits feed overflow detection.

## Timing
- Reset values: result=0, result_valid=0, err=0, ovf=0, state=S_START, all accumulators 0.
- Latency: result, err and ovf are registered. They update on the same edge that accepts EQ, with result_valid high for exactly that following cycle.
- Back-to-back: a character in the cycle after EQ is accepted as the first character of a new expression. No bubble is required.
- in_valid low: no state, accumulator or output change, except that result_valid drops to 0.
- clr mid-expression: all partial state is discarded immediately. The next character starts a fresh expression.
- No backpressure: the block accepts every valid character.

## Configuration
- EXPR_EVAL_OVF_EN defined: ovf_acc sets when any truncated product bit (bits W+3..W) or the final sum carry is nonzero. On completion it is reported on `ovf`.
- EXPR_EVAL_OVF_EN undefined: no detection logic is built, and `ovf` is tied to 0. The port is still present, so the interface does not change.

## Structure
- Shared package expr_pkg: state enum (S_START, S_OPND, S_OPER, S_ERR), character-class enum (CC_DIGIT, CC_PLUS, CC_MUL, CC_EQ, CC_ILL), and ASCII constants for `0`, `9`, `+`, `*`, `=`.
- One sub-module, expr_char_class: combinational in[7:0] → class and digit value[3:0]. The FSM and datapath stay in expr_eval.

## Test plan
- `1+2*3=` with in_valid held high → result_valid pulse with result=7, err=0, ovf=0.
- `9*9*9+8*7=`, with in_valid dropped for 2 cycles mid-stream → result=785, err=0. The gap does not change the result.
- `12+3=`, then `+1=`, then `=` → three pulses, each with err=1 and result=0. A following `4=` gives result=4, err=0.
- W=8, `9*9*9=` → result=217 (729 mod 256). ovf=1 with EXPR_EVAL_OVF_EN; ovf=0 without it.
- `5*` then a clr pulse, then `2=` → result=2, err=0, and no result_valid before the `=`.
- `3+a=` → err=1. A back-to-back `6*7=` starting in the cycle after the first `=` → result=42, err=0.

Source files
------------

// File: rtl/expr_pkg.sv
// expr_pkg: shared types and constants for the streaming expression evaluator.
//   state_t : evaluator FSM states
//   cc_t    : character classes produced by expr_char_class
//   CH_*    : ASCII codes recognised by the evaluator
package expr_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_OPND  = 2'd1,
    S_OPER  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CC_DIGIT = 3'd0,
    CC_PLUS  = 3'd1,
    CC_MUL   = 3'd2,
    CC_EQ    = 3'd3,
    CC_ILL   = 3'd4
  } cc_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

endpackage

// File: rtl/expr_char_class.sv
// expr_char_class: combinational ASCII classifier.
//   in   : input character
//   cls  : character class (digit, plus, mul, eq, illegal)
//   dval : digit value 0..9 when cls is CC_DIGIT, otherwise 0
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output cc_t        cls,
  output logic [3:0] dval
);

  always_comb begin
    cls  = CC_ILL;
    dval = 4'd0;
    if (in >= CH_0 && in <= CH_9) begin
      cls  = CC_DIGIT;
      // '0' is 0x30, so the low nibble is the digit value directly.
      dval = in[3:0];
    end else if (in == CH_PLUS) begin
      cls = CC_PLUS;
    end else if (in == CH_MUL) begin
      cls = CC_MUL;
    end else if (in == CH_EQ) begin
      cls = CC_EQ;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit expressions such as "1+2*3=".
// '*' binds tighter than '+'; arithmetic is modulo 2^W.
//   clk, clr     : clock (rising edge), asynchronous active-high reset
//   in, in_valid : character stream
//   result       : value of the last completed expression (0 on error)
//   result_valid : one-cycle pulse on the cycle after '=' is accepted
//   err          : syntax error flag of the last completed expression
//   ovf          : overflow flag of the last completed expression
// Handshake: a character is consumed on every rising clk edge where in_valid
// is high; there is no ready, the block always accepts.
// Build option: define EXPR_EVAL_OVF_EN to build overflow detection;
// otherwise ovf is constant 0.
// The FSM state is kept in the signal 'state' for debug observation.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         ovf
);

  state_t       state, state_nxt;
  logic [W-1:0] sum, sum_nxt;
  logic [W-1:0] term, term_nxt;
  logic         mul_pend, mul_pend_nxt;
  logic         err_acc, err_acc_nxt;
  logic         ovf_acc, ovf_acc_nxt;
  logic [W-1:0] result_nxt;
  logic         result_valid_nxt, err_nxt, ovf_nxt;

  cc_t          cls;
  logic [3:0]   dval;

  expr_char_class u_cc (
    .in   (in),
    .cls  (cls),
    .dval (dval)
  );

  // One multiplier (term*d) and one adder (sum+term) serve every state.
  logic [W-1:0] prod, sum_w;
  logic         prod_ovf, sum_ovf;

`ifdef EXPR_EVAL_OVF_EN
  logic [W+3:0] prod_full;
  logic [W:0]   sum_full;
  assign prod_full = (W+4)'(term) * (W+4)'(dval);
  assign sum_full  = {1'b0, sum} + {1'b0, term};
  assign prod      = prod_full[W-1:0];
  assign sum_w     = sum_full[W-1:0];
  assign prod_ovf  = |prod_full[W+3:W];
  assign sum_ovf   = sum_full[W];
`else
  assign prod     = term * W'(dval);
  assign sum_w    = sum + term;
  assign prod_ovf = 1'b0;
  assign sum_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= S_START;
      sum          <= '0;
      term         <= '0;
      mul_pend     <= 1'b0;
      err_acc      <= 1'b0;
      ovf_acc      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      state        <= state_nxt;
      sum          <= sum_nxt;
      term         <= term_nxt;
      mul_pend     <= mul_pend_nxt;
      err_acc      <= err_acc_nxt;
      ovf_acc      <= ovf_acc_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      err          <= err_nxt;
      ovf          <= ovf_nxt;
    end
  end

  always_comb begin
    logic err_c;
    state_nxt        = state;
    sum_nxt          = sum;
    term_nxt         = term;
    mul_pend_nxt     = mul_pend;
    err_acc_nxt      = err_acc;
    ovf_acc_nxt      = ovf_acc;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    err_nxt          = err;
    ovf_nxt          = ovf;
    // Only a '=' arriving right after an operand closes a well-formed expression.
    err_c            = (state != S_OPND) || err_acc;

    if (in_valid) begin
      if (cls == CC_EQ) begin
        result_nxt       = err_c ? '0 : sum_w;
        err_nxt          = err_c;
        ovf_nxt          = ovf_acc | (sum_ovf & ~err_c);
        result_valid_nxt = 1'b1;
        state_nxt        = S_START;
        sum_nxt          = '0;
        term_nxt         = '0;
        mul_pend_nxt     = 1'b0;
        err_acc_nxt      = 1'b0;
        ovf_acc_nxt      = 1'b0;
      end else begin
        case (state)
          S_START: begin
            if (cls == CC_DIGIT) begin
              term_nxt     = W'(dval);
              mul_pend_nxt = 1'b0;
              state_nxt    = S_OPND;
            end else begin
              err_acc_nxt = 1'b1;
              state_nxt   = S_ERR;
            end
          end
          S_OPND: begin
            if (cls == CC_PLUS) begin
              sum_nxt      = sum_w;
              ovf_acc_nxt  = ovf_acc | sum_ovf;
              mul_pend_nxt = 1'b0;
              state_nxt    = S_OPER;
            end else if (cls == CC_MUL) begin
              mul_pend_nxt = 1'b1;
              state_nxt    = S_OPER;
            end else begin
              err_acc_nxt = 1'b1;
              state_nxt   = S_ERR;
            end
          end
          S_OPER: begin
            if (cls == CC_DIGIT) begin
              if (mul_pend) begin
                term_nxt    = prod;
                ovf_acc_nxt = ovf_acc | prod_ovf;
              end else begin
                term_nxt = W'(dval);
              end
              state_nxt = S_OPND;
            end else begin
              err_acc_nxt = 1'b1;
              state_nxt   = S_ERR;
            end
          end
          default: begin
            state_nxt = S_ERR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

  logic        clk;
  logic        clr;
  logic [7:0]  ch;
  logic        ch_valid;
  logic [15:0] result;
  logic        result_valid, err, ovf;
  logic [7:0]  result8;
  logic        result_valid8, err8, ovf8;

  int nchecks = 0;
  int nfail   = 0;

`ifdef EXPR_EVAL_OVF_EN
  localparam logic OVF_EXP8 = 1'b1;
`else
  localparam logic OVF_EXP8 = 1'b0;
`endif

  expr_eval #(.W(16)) dut (
    .clk(clk), .clr(clr), .in(ch), .in_valid(ch_valid),
    .result(result), .result_valid(result_valid), .err(err), .ovf(ovf)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in(ch), .in_valid(ch_valid),
    .result(result8), .result_valid(result_valid8), .err(err8), .ovf(ovf8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change on negedge; outputs sampled 1 ns after posedge
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ch       = c;
    ch_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch_valid = 1'b0;
      ch       = 8'h00;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    ch = 8'h00; ch_valid = 1'b0; clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchecks++; if (result !== 16'd0) begin nfail++; $display("FAIL reset_result got %0d want 0", result); end
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL reset_rv got %b want 0", result_valid); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err got %b want 0", err); end
    nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    @(negedge clk); clr = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    send_str("1+2");
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL basic_early_rv got %b want 0", result_valid); end
    send_str("*3=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL basic_rv got %b want 1", result_valid); end
    nchecks++; if (result !== 16'd7) begin nfail++; $display("FAIL basic_result got %0d want 7", result); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL basic_err got %b want 0", err); end
    nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL basic_ovf got %b want 0", ovf); end
    idle(1);
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL basic_rv_drop got %b want 0", result_valid); end
    nchecks++; if (result !== 16'd7) begin nfail++; $display("FAIL basic_hold got %0d want 7", result); end
  endtask

  task automatic test_gap();
    send_str("9*9*9+");
    idle(2);
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL gap_rv got %b want 0", result_valid); end
    send_str("8*7=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL gap_done_rv got %b want 1", result_valid); end
    nchecks++; if (result !== 16'd785) begin nfail++; $display("FAIL gap_result got %0d want 785", result); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL gap_err got %b want 0", err); end
    idle(1);
  endtask

  task automatic test_errors();
    send_str("12+3=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL err1_rv got %b want 1", result_valid); end
    nchecks++; if (err !== 1'b1) begin nfail++; $display("FAIL err1_err got %b want 1", err); end
    nchecks++; if (result !== 16'd0) begin nfail++; $display("FAIL err1_result got %0d want 0", result); end
    idle(1);
    send_str("+1=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL err2_rv got %b want 1", result_valid); end
    nchecks++; if (err !== 1'b1) begin nfail++; $display("FAIL err2_err got %b want 1", err); end
    nchecks++; if (result !== 16'd0) begin nfail++; $display("FAIL err2_result got %0d want 0", result); end
    idle(1);
    send_str("=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL err3_rv got %b want 1", result_valid); end
    nchecks++; if (err !== 1'b1) begin nfail++; $display("FAIL err3_err got %b want 1", err); end
    nchecks++; if (result !== 16'd0) begin nfail++; $display("FAIL err3_result got %0d want 0", result); end
    idle(1);
    nchecks++; if (err !== 1'b1) begin nfail++; $display("FAIL err3_hold got %b want 1", err); end
    send_str("4=");
    nchecks++; if (result !== 16'd4) begin nfail++; $display("FAIL err_recover_result got %0d want 4", result); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL err_recover_err got %b want 0", err); end
    idle(1);
  endtask

  task automatic test_overflow();
    send_str("9*9*9=");
    nchecks++; if (result_valid8 !== 1'b1) begin nfail++; $display("FAIL ovf8_rv got %b want 1", result_valid8); end
    nchecks++; if (result8 !== 8'd217) begin nfail++; $display("FAIL ovf8_result got %0d want 217", result8); end
    nchecks++; if (ovf8 !== OVF_EXP8) begin nfail++; $display("FAIL ovf8_flag got %b want %b", ovf8, OVF_EXP8); end
    nchecks++; if (err8 !== 1'b0) begin nfail++; $display("FAIL ovf8_err got %b want 0", err8); end
    nchecks++; if (result !== 16'd729) begin nfail++; $display("FAIL ovf16_result got %0d want 729", result); end
    nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf16_flag got %b want 0", ovf); end
    // ovf is sticky only within one expression
    idle(1);
    send_str("2*3=");
    nchecks++; if (ovf8 !== 1'b0) begin nfail++; $display("FAIL ovf8_clear got %b want 0", ovf8); end
    nchecks++; if (result8 !== 8'd6) begin nfail++; $display("FAIL ovf8_next got %0d want 6", result8); end
    idle(1);
  endtask

  task automatic test_clr();
    send_str("5*");
    @(negedge clk);
    ch_valid = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    @(posedge clk); #1;
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL clr_rv got %b want 0", result_valid); end
    send_str("2");
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL clr_rv2 got %b want 0", result_valid); end
    send_str("=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL clr_done_rv got %b want 1", result_valid); end
    nchecks++; if (result !== 16'd2) begin nfail++; $display("FAIL clr_result got %0d want 2", result); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL clr_err got %b want 0", err); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    send_str("3+a=");
    nchecks++; if (err !== 1'b1) begin nfail++; $display("FAIL b2b_first_err got %b want 1", err); end
    nchecks++; if (result !== 16'd0) begin nfail++; $display("FAIL b2b_first_result got %0d want 0", result); end
    send_str("6");
    nchecks++; if (result_valid !== 1'b0) begin nfail++; $display("FAIL b2b_rv_drop got %b want 0", result_valid); end
    send_str("*7=");
    nchecks++; if (result_valid !== 1'b1) begin nfail++; $display("FAIL b2b_rv got %b want 1", result_valid); end
    nchecks++; if (result !== 16'd42) begin nfail++; $display("FAIL b2b_result got %0d want 42", result); end
    nchecks++; if (err !== 1'b0) begin nfail++; $display("FAIL b2b_err got %b want 0", err); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_errors();
    test_overflow();
    test_clr();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
